seg_display_sched: RTL and testbench

Display scheduler for the mole game's 8-digit 7-segment array. Owns the display and chooses between four content sources: power-on lamp test, normal status (lives/score/time), a timed "hit" flash showing points just earned, and a blinking game-over screen. It drives the digit buffer into a time-multiplexed scan sub-block and sits between the game FSM and the board's segment/digit pins.

---
 rtl/seg_pkg.sv | 39 +++
 rtl/seg_scan_mux.sv | 38 +++
 rtl/seg_display_sched.sv | 99 +++++++++
 tb/tb_seg_display_sched.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared state encoding, digit type and 7-segment codes for the display scheduler
package seg_pkg;

    typedef enum logic [1:0] {
        LAMP   = 2'd0,
        STATUS = 2'd1,
        FLASH  = 2'd2,
        OVER   = 2'd3
    } state_t;

    typedef logic [3:0] digit_t;

    localparam logic [7:0] SEG_0     = 8'hFC;
    localparam logic [7:0] SEG_1     = 8'h60;
    localparam logic [7:0] SEG_2     = 8'hDA;
    localparam logic [7:0] SEG_3     = 8'hF2;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'hB6;
    localparam logic [7:0] SEG_6     = 8'hBE;
    localparam logic [7:0] SEG_7     = 8'hE0;
    localparam logic [7:0] SEG_8     = 8'hFE;
    localparam logic [7:0] SEG_9     = 8'hF6;
    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_LAMP  = 8'hFF;

    function automatic logic [7:0] seg_encode(input digit_t d);
        return d == 4'd0 ? SEG_0 :
               d == 4'd1 ? SEG_1 :
               d == 4'd2 ? SEG_2 :
               d == 4'd3 ? SEG_3 :
               d == 4'd4 ? SEG_4 :
               d == 4'd5 ? SEG_5 :
               d == 4'd6 ? SEG_6 :
               d == 4'd7 ? SEG_7 :
               d == 4'd8 ? SEG_8 :
               d == 4'd9 ? SEG_9 : SEG_BLANK;
    endfunction

endpackage

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed digit scan with registered segment/digit-select outputs
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 1000
) (
    input  logic           clk_1mhz,
    input  logic           rst_n,
    input  digit_t [7:0]   digits,
    input  logic   [7:0]   blank,
    input  logic           lamp,
    output logic   [7:0]   seg_out,
    output logic   [7:0]   array_out
);

    localparam int RW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;

    logic [RW-1:0] ref_cnt;
    logic [2:0]    scan_idx;
    logic          wrap;

    assign wrap = ref_cnt == RW'(REFRESH_DIV - 1);

    always_ff @(posedge clk_1mhz or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt   <= '0;
            scan_idx  <= 3'd0;
            seg_out   <= SEG_BLANK;
            array_out <= 8'hFF;
        end else begin
            ref_cnt   <= wrap ? '0 : ref_cnt + 1'b1;
            scan_idx  <= scan_idx + 3'(wrap);
            seg_out   <= lamp ? SEG_LAMP : blank[scan_idx] ? SEG_BLANK : seg_encode(digits[scan_idx]);
            array_out <= ~(8'h01 << scan_idx);
        end
    end

endmodule

// File: rtl/seg_display_sched.sv
// seg_display_sched: picks lamp-test, status, hit-flash or blinking game-over content for the 8-digit display
module seg_display_sched
    import seg_pkg::*;
#(
    parameter int CLK_HZ      = 1_000_000,
    parameter int REFRESH_DIV = 1000,
    parameter int LAMP_MS     = 1000,
    parameter int FLASH_MS    = 500,
    parameter int BLINK_MS    = 250
) (
    input  logic        clk_1mhz,
    input  logic        rst_n,
    input  logic [1:0]  lives,
    input  logic [9:0]  score,
    input  logic [6:0]  time_left,
    input  logic        evt_req,
    input  logic [3:0]  evt_val,
    input  logic        game_over,
    output logic        busy,
    output logic [1:0]  mode,
    output logic [7:0]  seg_out,
    output logic [7:0]  array_out
);

    localparam int PRE = CLK_HZ / 1000;
    localparam int PW  = PRE > 1 ? $clog2(PRE) : 1;

    state_t        st, nxt;
    logic [PW-1:0] pre;
    logic [15:0]   ms, dur;
    logic          tick, done, latch, restart, phase;
    digit_t        evt_d, ev, hund, tens, ones, tt, to, lv;
    logic [9:0]    sc;
    logic [6:0]    tl;
    logic          hz, hz2;
    digit_t [7:0]  digits;
    logic   [7:0]  blank;

    assign tick = pre == PW'(PRE - 1);
    assign dur  = st == LAMP ? 16'(LAMP_MS) : st == FLASH ? 16'(FLASH_MS) : 16'(BLINK_MS);
    assign done = tick && ms == dur - 16'd1;

    // game_over outranks evt_req everywhere except LAMP, and evt_req outranks flash expiry
    assign nxt = st == LAMP ? (done ? (game_over ? OVER : STATUS) : LAMP)
               : game_over ? OVER
               : st == OVER ? STATUS
               : evt_req ? FLASH
               : st == FLASH && done ? STATUS : st;
    assign latch   = evt_req && !game_over && (st == STATUS || st == FLASH);
    assign restart = nxt != st || latch;

    assign sc   = score > 10'd999 ? 10'd999 : score;
    assign tl   = time_left > 7'd99 ? 7'd99 : time_left;
    assign ev   = evt_val > 4'd9 ? 4'd9 : evt_val;
    assign hund = 4'(sc / 10'd100);
    assign tens = 4'((sc / 10'd10) % 10'd10);
    assign ones = 4'(sc % 10'd10);
    assign tt   = 4'(tl / 7'd10);
    assign to   = 4'(tl % 7'd10);
    assign lv   = {2'b00, lives};
    assign hz   = hund == 4'd0;
    assign hz2  = hz && tens == 4'd0;

    assign digits = {lv, 4'd0, st == FLASH ? 4'd0 : hund, st == FLASH ? 4'd0 : tens,
                     st == FLASH ? evt_d : ones, 4'd0, tt, to};
    assign blank  = st == FLASH ? 8'b0111_0100
                  : st == OVER  ? {2'b01, phase | hz, phase | hz2, phase, 3'b111}
                  : {2'b01, hz, hz2, 4'b0100};

    assign busy = st == LAMP || st == FLASH;
    assign mode = st;

    always_ff @(posedge clk_1mhz or negedge rst_n) begin
        if (!rst_n) begin
            st    <= LAMP;
            pre   <= '0;
            ms    <= 16'd0;
            phase <= 1'b0;
            evt_d <= 4'd0;
        end else begin
            st    <= nxt;
            pre   <= restart || tick ? '0 : pre + 1'b1;
            ms    <= restart || done ? 16'd0 : ms + 16'(tick);
            phase <= restart ? 1'b0 : st == OVER && done ? ~phase : phase;
            evt_d <= latch ? ev : evt_d;
        end
    end

    seg_scan_mux #(.REFRESH_DIV(REFRESH_DIV)) u_scan (
        .clk_1mhz  (clk_1mhz),
        .rst_n     (rst_n),
        .digits    (digits),
        .blank     (blank),
        .lamp      (st == LAMP),
        .seg_out   (seg_out),
        .array_out (array_out)
    );

endmodule

// File: tb/tb_seg_display_sched.sv
// tb_seg_display_sched: directed checks of lamp test, status layout, flash timing, blink and reset,
// run with a scaled-down clock so every duration is 1/100 of the 1 MHz values.
module tb_seg_display_sched;

    localparam int CLK_HZ      = 10_000;
    localparam int REFRESH_DIV = 10;
    localparam int LAMP_MS     = 1000;
    localparam int FLASH_MS    = 500;
    localparam int BLINK_MS    = 250;
    localparam int PRE         = CLK_HZ / 1000;
    localparam int LAMP_C      = LAMP_MS * PRE;
    localparam int FLASH_C     = FLASH_MS * PRE;
    localparam int BLINK_C     = BLINK_MS * PRE;

    logic       clk_1mhz = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] lives = 2'd2;
    logic [9:0] score = 10'd7;
    logic [6:0] time_left = 7'd5;
    logic       evt_req = 1'b0;
    logic [3:0] evt_val = 4'd0;
    logic       game_over = 1'b0;
    logic       busy;
    logic [1:0] mode;
    logic [7:0] seg_out, array_out;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int e, g;

    seg_display_sched #(
        .CLK_HZ(CLK_HZ), .REFRESH_DIV(REFRESH_DIV), .LAMP_MS(LAMP_MS),
        .FLASH_MS(FLASH_MS), .BLINK_MS(BLINK_MS)
    ) dut (
        .clk_1mhz(clk_1mhz), .rst_n(rst_n), .lives(lives), .score(score),
        .time_left(time_left), .evt_req(evt_req), .evt_val(evt_val),
        .game_over(game_over), .busy(busy), .mode(mode),
        .seg_out(seg_out), .array_out(array_out)
    );

    always #5 clk_1mhz = ~clk_1mhz;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_1mhz);
            #1;
            cyc++;
        end
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step(1);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic read_row(output logic [63:0] row);
        logic [7:0] seen;
        logic [7:0] sel;
        seen = 8'h00;
        row = 64'h0;
        for (int i = 0; i < 200 && seen != 8'hFF; i++) begin
            step(1);
            for (int d = 0; d < 8; d++) begin
                sel = ~(8'h01 << d);
                if (array_out == sel) begin
                    row[8*d +: 8] = seg_out;
                    seen[d] = 1'b1;
                end
            end
        end
        chk("scan_cover", {24'h0, seen}, 32'hFF);
    endtask

    task automatic check_row(input string tag, input logic [63:0] exp);
        logic [63:0] r;
        read_row(r);
        for (int d = 0; d < 8; d++)
            chk($sformatf("%s_d%0d", tag, d), {24'h0, r[8*d +: 8]}, {24'h0, exp[8*d +: 8]});
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_seg", {24'h0, seg_out}, 32'h00);
        chk("rst_array", {24'h0, array_out}, 32'hFF);
        chk("rst_busy", {31'h0, busy}, 32'h1);
        chk("rst_mode", {30'h0, mode}, 32'h0);
        step(2);
        rst_n = 1'b1;
        cyc = 0;

        step(1);
        chk("lamp_array1", {24'h0, array_out}, 32'hFE);
        chk("lamp_seg1", {24'h0, seg_out}, 32'hFF);
        step_to(10);
        chk("scan_hold", {24'h0, array_out}, 32'hFE);
        for (int j = 1; j <= 8; j++) begin
            step_to(10 * j + 1);
            chk($sformatf("scan_%0d", j), {24'h0, array_out}, {24'h0, ~(8'h01 << (j % 8))});
            chk($sformatf("lamp_seg_%0d", j), {24'h0, seg_out}, 32'hFF);
        end
        step_to(LAMP_C - 1);
        chk("lamp_end_mode", {30'h0, mode}, 32'h0);
        chk("lamp_end_busy", {31'h0, busy}, 32'h1);
        step(1);
        chk("status_mode", {30'h0, mode}, 32'h1);
        chk("status_busy", {31'h0, busy}, 32'h0);

        check_row("st_7_5", {8'hDA, 8'h00, 8'h00, 8'h00, 8'hE0, 8'h00, 8'hFC, 8'hB6});
        score = 10'd1023; time_left = 7'd120;
        check_row("st_clamp", {8'hDA, 8'h00, 8'hF6, 8'hF6, 8'hF6, 8'h00, 8'hF6, 8'hF6});
        score = 10'd40; time_left = 7'd9;
        check_row("st_40_9", {8'hDA, 8'h00, 8'h00, 8'h66, 8'hFC, 8'h00, 8'hFC, 8'hF6});
        score = 10'd105; time_left = 7'd99;
        check_row("st_105_99", {8'hDA, 8'h00, 8'h60, 8'hFC, 8'hB6, 8'h00, 8'hF6, 8'hF6});
        lives = 2'd3; score = 10'd0; time_left = 7'd0;
        check_row("st_zero", {8'hF2, 8'h00, 8'h00, 8'h00, 8'hFC, 8'h00, 8'hFC, 8'hFC});
        lives = 2'd2; score = 10'd7; time_left = 7'd5;

        evt_req = 1'b1; evt_val = 4'd3;
        step(1);
        e = cyc;
        evt_req = 1'b0; evt_val = 4'd0;
        chk("flash_mode", {30'h0, mode}, 32'h2);
        chk("flash_busy", {31'h0, busy}, 32'h1);
        check_row("flash_3", {8'hDA, 8'h00, 8'h00, 8'h00, 8'hF2, 8'h00, 8'hFC, 8'hB6});
        step_to(e + FLASH_C - 1);
        chk("flash_last", {30'h0, mode}, 32'h2);
        step(1);
        chk("flash_expire", {30'h0, mode}, 32'h1);

        step(20);
        evt_req = 1'b1; evt_val = 4'd5;
        step(1);
        e = cyc;
        evt_req = 1'b0;
        step_to(e + 4 * FLASH_C / 5 - 1);
        evt_req = 1'b1; evt_val = 4'd12;
        step(1);
        e = cyc;
        evt_req = 1'b0; evt_val = 4'd0;
        check_row("flash_12", {8'hDA, 8'h00, 8'h00, 8'h00, 8'hF6, 8'h00, 8'hFC, 8'hB6});
        step_to(e + FLASH_C / 5);
        chk("retrig_hold", {30'h0, mode}, 32'h2);
        step_to(e + FLASH_C - 1);
        chk("retrig_last", {30'h0, mode}, 32'h2);
        step(1);
        chk("retrig_expire", {30'h0, mode}, 32'h1);

        step(20);
        evt_req = 1'b1; evt_val = 4'd1;
        step(1);
        e = cyc;
        evt_req = 1'b0;
        step_to(e + FLASH_C - 1);
        evt_req = 1'b1;
        step(1);
        e = cyc;
        evt_req = 1'b0;
        chk("expiry_retrig", {30'h0, mode}, 32'h2);
        step_to(e + FLASH_C - 1);
        chk("expiry_retrig_last", {30'h0, mode}, 32'h2);
        step(1);
        chk("expiry_retrig_end", {30'h0, mode}, 32'h1);

        score = 10'd888;
        while ((cyc + 1) % (8 * REFRESH_DIV) != 15) step(1);
        game_over = 1'b1; evt_req = 1'b1; evt_val = 4'd7;
        step(1);
        g = cyc;
        evt_req = 1'b0;
        chk("over_mode", {30'h0, mode}, 32'h3);
        chk("over_busy", {31'h0, busy}, 32'h0);
        check_row("over_on", {8'hDA, 8'h00, 8'hFE, 8'hFE, 8'hFE, 8'h00, 8'h00, 8'h00});
        step_to(g + BLINK_C);
        chk("blink_sel_a", {24'h0, array_out}, 32'hF7);
        chk("blink_on_last", {24'h0, seg_out}, 32'hFE);
        step(1);
        chk("blink_off_first", {24'h0, seg_out}, 32'h00);
        step_to(g + 2 * BLINK_C);
        chk("blink_sel_b", {24'h0, array_out}, 32'hDF);
        chk("blink_off_last", {24'h0, seg_out}, 32'h00);
        step(1);
        chk("blink_on_again", {24'h0, seg_out}, 32'hFE);
        game_over = 1'b0;
        step(1);
        chk("over_exit", {30'h0, mode}, 32'h1);

        step(20);
        evt_req = 1'b1; evt_val = 4'd9;
        step(1);
        evt_req = 1'b0;
        step(50);
        chk("pre_rst_flash", {30'h0, mode}, 32'h2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_seg", {24'h0, seg_out}, 32'h00);
        chk("mid_rst_array", {24'h0, array_out}, 32'hFF);
        chk("mid_rst_mode", {30'h0, mode}, 32'h0);
        chk("mid_rst_busy", {31'h0, busy}, 32'h1);
        step(2);
        rst_n = 1'b1;
        cyc = 0;
        step_to(100);
        chk("relamp_mode", {30'h0, mode}, 32'h0);
        chk("relamp_seg", {24'h0, seg_out}, 32'hFF);
        evt_req = 1'b1;
        step(1);
        evt_req = 1'b0;
        chk("lamp_ignores_evt", {30'h0, mode}, 32'h0);
        step_to(LAMP_C - 1);
        chk("relamp_last", {30'h0, mode}, 32'h0);
        step(1);
        chk("relamp_exit", {30'h0, mode}, 32'h1);
        check_row("post_rst", {8'hDA, 8'h00, 8'hFE, 8'hFE, 8'hFE, 8'h00, 8'hFC, 8'hB6});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
